alu_divider: RTL and testbench
==============================

// Module: alu_divider
// PURPOSE
//   Iterative unsigned divider that replaces the single-cycle '/' and '%' paths of the ALU.
//   Radix-2 restoring division, one quotient bit per clock.
//   Produces quotient and remainder together with a start/busy/done handshake.
//   Sits beside the ALU in the execute stage and feeds the ALU_DIV / ALU_MOD result-mux
//   inputs; the pipeline controller stalls on o_busy.
// PARAMETERS
//   WIDTH  32  operand, quotient and remainder width in bits (>= 2)
// PORTS
//   i_clk       in   1      clock; all state changes on the rising edge
//   i_rst       in   1      synchronous reset, active high
//   i_start     in   1      request a division; sampled only when the unit is not busy
//   i_mod       in   1      result select captured at start: 0 = quotient, 1 = remainder
//   i_op1       in   WIDTH  dividend, captured at start
//   i_op2       in   WIDTH  divisor, captured at start
//   o_busy      out  1      high while a division is in progress
//   o_done      out  1      one-cycle pulse when results become valid
//   o_dbz       out  1      divisor was zero for the last completed operation
//   o_quot      out  WIDTH  quotient
//   o_rem       out  WIDTH  remainder
//   o_res       out  WIDTH  o_rem if captured i_mod = 1, otherwise o_quot
// BEHAVIOUR
//   Reset: one clock and reset for the whole unit; reset is synchronous and active-high.
//     - i_rst high at an edge sets state IDLE, counter 0.
//     - o_busy = o_done = o_dbz = 0; o_quot = o_rem = o_res = 0.
//     - Reset has priority over i_start.
//   States:
//     - IDLE: i_start=1 captures the operands and i_mod, clears the partial remainder,
//       and moves to RUN with counter 0. If i_op2 == 0, it moves to DONE instead.
//     - RUN: each edge performs one restoring step: shift {rem, dividend} left by one;
//       if rem >= divisor, subtract and set quotient LSB to 1, else set it to 0;
//       counter increments. After WIDTH steps (counter == WIDTH-1 at the edge), move to DONE.
//     - DONE: lasts exactly one cycle. o_done = 1 and results are valid.
//       Next state is RUN (or DONE if the divisor is zero) when i_start=1, otherwise IDLE.
//   Latency: with start sampled at edge E0, o_done is high in the cycle after edge E0+WIDTH.
//     That is WIDTH+1 cycles from start; for a zero divisor it is 1 cycle.
//   o_busy = 1 in RUN only; it is 0 in IDLE and DONE.
//   i_start is ignored while in RUN: no queueing and no restart.
//   Divide by zero: o_quot = all ones, o_rem = dividend, o_dbz = 1.
//   o_dbz is cleared when the next start is accepted.
//   Results: o_quot, o_rem and o_res update only on entry to DONE.
//     They hold their values through IDLE until the next DONE, so they are stable for
//     late consumers. They are not valid mid-RUN (internal registers are separate).
//   Arithmetic is unsigned; no signed mode.
//     Invariant on completion: q*d + r == dividend and r < d, for d != 0.
//   Reset during RUN aborts the operation: no o_done pulse, outputs cleared to 0.
//   Start accepted in the DONE cycle:
//     - the current o_done still pulses;
//     - outputs keep the old result until the new DONE.
// TESTING
//   1. Reset, then start with 100 / 7, i_mod = 0 -> o_busy for 32 cycles;
//      o_done at cycle 33; o_quot = 14, o_rem = 2, o_res = 14.
//   2. 0xFFFFFFFF / 1, i_mod = 1 -> o_quot = 0xFFFFFFFF, o_rem = 0, o_res = 0, o_dbz = 0.
//   3. 1234 / 0 -> o_done 1 cycle after start, o_busy never high;
//      o_quot = 0xFFFFFFFF, o_rem = 1234, o_dbz = 1.
//   4. Start 50 / 3, then pulse i_start with 9 / 2 at cycle 10 -> second request ignored;
//      result 16 r 2 at cycle 33.
//   5. Assert i_rst at cycle 15 of a division -> next cycle o_busy = 0 and outputs 0;
//      no o_done pulse follows.
//   6. Back-to-back: i_start held high with 7 / 7 then 8 / 3 -> done pulses at cycles
//      33 and 66; results 1 r 0, then 2 r 2.

Source files
------------

// File: rtl/alu_divider.sv
// Iterative radix-2 restoring unsigned divider producing quotient and remainder
// with a start/busy/done handshake for the execute-stage result mux.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_mod,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_dbz,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_res
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_n;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] dvd_r, dvs_r, rem_r;
    logic             mod_r;
    logic             busy_r, done_r, dbz_r;
    logic [WIDTH-1:0] quot_out_r, rem_out_r, res_out_r;

    logic             accept_s;
    logic             zero_div_s;
    logic [WIDTH:0]   shifted_s, diff_s;
    logic             qbit_s;
    logic [WIDTH-1:0] rem_next_s, quot_next_s;

    // Next-state selection and start acceptance.
    always_comb begin
        state_n    = state_r;
        accept_s   = 1'b0;
        zero_div_s = (i_op2 == {WIDTH{1'b0}});
        case (state_r)
            IDLE, DONE: begin
                if (i_start) begin
                    accept_s = 1'b1;
                    state_n  = zero_div_s ? DONE : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST) begin
                    state_n = DONE;
                end else begin
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // One restoring step: borrow out of the trial subtraction means the divisor did not fit.
    always_comb begin
        shifted_s   = {rem_r, dvd_r[WIDTH-1]};
        diff_s      = shifted_s - {1'b0, dvs_r};
        qbit_s      = ~diff_s[WIDTH];
        rem_next_s  = qbit_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
        quot_next_s = {dvd_r[WIDTH-2:0], qbit_s};
    end

    // State, datapath and result registers; results change only on entry to DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            dvd_r      <= {WIDTH{1'b0}};
            dvs_r      <= {WIDTH{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            mod_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
            quot_out_r <= {WIDTH{1'b0}};
            rem_out_r  <= {WIDTH{1'b0}};
            res_out_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n == RUN);
            done_r  <= (state_n == DONE);
            if (accept_s) begin
                dvd_r <= i_op1;
                dvs_r <= i_op2;
                rem_r <= {WIDTH{1'b0}};
                cnt_r <= {CW{1'b0}};
                mod_r <= i_mod;
                dbz_r <= zero_div_s;
                if (zero_div_s) begin
                    quot_out_r <= {WIDTH{1'b1}};
                    rem_out_r  <= i_op1;
                    res_out_r  <= i_mod ? i_op1 : {WIDTH{1'b1}};
                end else begin
                    quot_out_r <= quot_out_r;
                end
            end else if (state_r == RUN) begin
                dvd_r <= quot_next_s;
                rem_r <= rem_next_s;
                cnt_r <= cnt_r + CW'(1);
                if (cnt_r == LAST) begin
                    quot_out_r <= quot_next_s;
                    rem_out_r  <= rem_next_s;
                    res_out_r  <= mod_r ? rem_next_s : quot_next_s;
                end else begin
                    quot_out_r <= quot_out_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign o_busy = busy_r;
    assign o_done = done_r;
    assign o_dbz  = dbz_r;
    assign o_quot = quot_out_r;
    assign o_rem  = rem_out_r;
    assign o_res  = res_out_r;

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: vector table plus scoreboard of expected results.
module tb_alu_divider;

    logic        i_clk = 1'b0;
    logic        i_rst, i_start, i_mod;
    logic [31:0] i_op1, i_op2;
    logic        o_busy, o_done, o_dbz;
    logic [31:0] o_quot, o_rem, o_res;

    alu_divider #(.WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mod(i_mod),
        .i_op1(i_op1), .i_op2(i_op2), .o_busy(o_busy), .o_done(o_done),
        .o_dbz(o_dbz), .o_quot(o_quot), .o_rem(o_rem), .o_res(o_res)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] op1, op2;
        logic        mod;
        logic [31:0] quot, rem;
        logic        dbz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] quot, rem, res;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    endtask

    // Drives one request, then waits for its done pulse and scores it.
    task automatic run_op(input logic [31:0] op1, input logic [31:0] op2, input logic mod,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                          input int lat, input bit hold, input int poke_at);
        exp_t e;
        int cycles, busy_cnt;
        logic [31:0] prev;
        bit hold_bad;
        i_start = 1'b1; i_op1 = op1; i_op2 = op2; i_mod = mod;
        e.quot = eq; e.rem = er; e.res = mod ? er : eq; e.dbz = edbz;
        sb.push_back(e);
        prev = o_quot; hold_bad = 1'b0; cycles = 0; busy_cnt = 0;
        do begin
            @(posedge i_clk); #1;
            cycles++;
            if (cycles == 1 && !hold) i_start = 1'b0;
            if (poke_at != 0 && cycles == poke_at) begin
                i_start = 1'b1; i_op1 = 32'd9; i_op2 = 32'd2;
            end
            if (poke_at != 0 && cycles == poke_at + 1) i_start = 1'b0;
            if (o_busy) busy_cnt++;
            if (!o_done && o_quot !== prev) hold_bad = 1'b1;
        end while (!o_done && cycles < 200);
        if (!o_done) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("quot", o_quot, e.quot);
            chk("rem", o_rem, e.rem);
            chk("res", o_res, e.res);
            chk("dbz", {31'd0, o_dbz}, {31'd0, e.dbz});
        end
        chk("latency", 32'(cycles), 32'(lat));
        chk("busy_cycles", 32'(busy_cnt), 32'(lat - 1));
        chk("hold_mid_run", {31'd0, hold_bad}, 32'd0);
    endtask

    task automatic idle_cycle();
        @(posedge i_clk); #1;
    endtask

    initial begin
        int done_cnt;
        logic [31:0] a, b;
        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,      1'b0, 33};
        vecs[1] = '{32'hFFFFFFFF,   32'd1,          1'b1, 32'hFFFFFFFF,   32'd0,      1'b0, 33};
        vecs[2] = '{32'd1234,       32'd0,          1'b0, 32'hFFFFFFFF,   32'd1234,   1'b1, 1};
        vecs[3] = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0,      1'b0, 33};
        vecs[4] = '{32'd5,          32'd9,          1'b1, 32'd0,          32'd5,      1'b0, 33};
        vecs[5] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,      1'b0, 33};
        vecs[6] = '{32'h80000000,   32'd2,          1'b0, 32'h40000000,   32'd0,      1'b0, 33};
        vecs[7] = '{32'hFFFFFFFF,   32'd16,         1'b1, 32'h0FFFFFFF,   32'hF,      1'b0, 33};
        vecs[8] = '{32'h12345678,   32'h1000,       1'b0, 32'h12345,      32'h678,    1'b0, 33};

        i_rst = 1'b1; i_start = 1'b0; i_mod = 1'b0; i_op1 = 32'd0; i_op2 = 32'd0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_dbz", {31'd0, o_dbz}, 32'd0);
        chk("rst_quot", o_quot, 32'd0);
        chk("rst_rem", o_rem, 32'd0);
        chk("rst_res", o_res, 32'd0);
        i_rst = 1'b0;
        idle_cycle();

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op1, vecs[i].op2, vecs[i].mod, vecs[i].quot, vecs[i].rem,
                   vecs[i].dbz, vecs[i].lat, 1'b0, 0);
            idle_cycle();
            if (i == 0) begin
                repeat (3) idle_cycle();
                chk("idle_hold_quot", o_quot, 32'd14);
                chk("idle_hold_done", {31'd0, o_done}, 32'd0);
            end
        end

        // Second request during RUN must be ignored.
        run_op(32'd50, 32'd3, 1'b0, 32'd16, 32'd2, 1'b0, 33, 1'b0, 10);
        done_cnt = 0;
        repeat (40) begin
            idle_cycle();
            if (o_done) done_cnt++;
        end
        chk("no_queued_done", 32'(done_cnt), 32'd0);

        // Back-to-back with start held through the first DONE.
        run_op(32'd7, 32'd7, 1'b0, 32'd1, 32'd0, 1'b0, 33, 1'b1, 0);
        run_op(32'd8, 32'd3, 1'b0, 32'd2, 32'd2, 1'b0, 33, 1'b0, 0);
        idle_cycle();

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i == 3) b = 32'd0;
            if (b == 32'd0)
                run_op(a, b, i[0], 32'hFFFFFFFF, a, 1'b1, 1, 1'b0, 0);
            else
                run_op(a, b, i[0], a / b, a % b, 1'b0, 33, 1'b0, 0);
            idle_cycle();
        end

        // Reset in the middle of a division aborts it.
        i_start = 1'b1; i_op1 = 32'd1000; i_op2 = 32'd3; i_mod = 1'b0;
        idle_cycle();
        i_start = 1'b0;
        repeat (13) idle_cycle();
        i_rst = 1'b1;
        idle_cycle();
        i_rst = 1'b0;
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_quot", o_quot, 32'd0);
        chk("abort_rem", o_rem, 32'd0);
        chk("abort_res", o_res, 32'd0);
        done_cnt = 0;
        repeat (40) begin
            idle_cycle();
            if (o_done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        run_op(32'd1000, 32'd3, 1'b1, 32'd333, 32'd1, 1'b0, 33, 1'b0, 0);
        idle_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
